// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter one frame at a time.
// The host pushes bytes. The drain FSM strobes txen_o with the head byte,
// then uses tx_ing_i to follow the frame until it completes. If tx_ing_i
// does not rise within START_TIMEOUT clocks, the byte is dropped and
// tx_err_o pulses.
// Optional build macro UART_TX_FIFO_STATS_EN adds sent/drop statistics counters.
module uart_tx_fifo #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     txen_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_ing_i,
    output logic                     tx_err_o
`ifdef UART_TX_FIFO_STATS_EN
    ,
    input  logic                     clr_stats_i,
    output logic [15:0]              sent_cnt_o,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [TW-1:0]   timer;
    logic            pop;
    logic            push;
    logic            drop;
    logic            timeout;

    // Drain FSM next-state: pop the head byte when the line is idle, then follow the frame.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_o && !tx_ing_i) begin
                    pop        = 1'b1;
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (tx_ing_i) begin
                    state_next = WAIT_DONE;
                end else if (timer == TW'(START_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_ing_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Push/drop decision and next occupancy. A same-cycle pop frees room in a full
    // FIFO, and a flush overrides both push and drop.
    always_comb begin
        push       = wr_en_i && (!full_o || pop) && !flush_i;
        drop       = wr_en_i && !push && !flush_i;
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // FSM state register and start-timeout timer, which is cleared on entry to WAIT_START and saturates.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                timer <= '0;
            end else if (state == WAIT_START && timer != TW'(START_TIMEOUT)) begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Storage array; contents need no reset because the count guards every read.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointers, count and registered status/strobe outputs.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
            overflow_o <= 1'b0;
            txen_o     <= 1'b0;
            tx_data_o  <= '0;
            tx_err_o   <= 1'b0;
        end else begin
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
            end
            count      <= count_next;
            full_o     <= (count_next == CW'(DEPTH));
            empty_o    <= (count_next == '0);
            overflow_o <= drop;
            txen_o     <= pop;
            if (pop) begin
                tx_data_o <= mem[rd_ptr];
            end
            tx_err_o   <= timeout;
        end
    end

    assign level_o = count;

`ifdef UART_TX_FIFO_STATS_EN
    // Saturating frame/drop statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sent_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else if (clr_stats_i) begin
            sent_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (state == WAIT_DONE && !tx_ing_i && sent_cnt_o != '1) begin
                sent_cnt_o <= sent_cnt_o + 16'd1;
            end
            if (drop && drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus a randomized phase. Each cycle is
// compared against a queue-based reference model. A simple UART TX stub
// answers txen_o by holding tx_ing_i high for a few clocks, or stays silent
// so that the start timeout occurs.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned START_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flush;
    logic        full_o, empty_o, overflow_o, txen_o, tx_err_o;
    logic [4:0]  level_o;
    logic [7:0]  tx_data_o;
    logic        tx_ing;
`ifdef UART_TX_FIFO_STATS_EN
    logic        clr;
    logic [15:0] sent_cnt_o, drop_cnt_o;
`endif

    uart_tx_fifo #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clock_i    (clk),
        .resetn_i   (resetn),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .flush_i    (flush),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .txen_o     (txen_o),
        .tx_data_o  (tx_data_o),
        .tx_ing_i   (tx_ing),
        .tx_err_o   (tx_err_o)
`ifdef UART_TX_FIFO_STATS_EN
        ,
        .clr_stats_i (clr),
        .sent_cnt_o  (sent_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: the queue holds the bytes waiting to be sent.
    // busy_phase: 0 = idle, 1 = strobe sent and waiting for start, 2 = frame running.
    logic [7:0] q[$];
    int         busy_phase = 0;
    int         age = 0;
    logic       m_txen = 0, m_ovf = 0, m_err = 0;
    logic [7:0] m_data = 0;
    int         sent_m = 0, drop_m = 0;

    // UART TX stub.
    bit stub_on = 0;
    int stub_busy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("level", 32'(level_o), 32'(q.size()));
        check("empty", 32'(empty_o), 32'(q.size() == 0));
        check("full", 32'(full_o), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("txen", 32'(txen_o), 32'(m_txen));
        check("tx_data", 32'(tx_data_o), 32'(m_data));
        check("tx_err", 32'(tx_err_o), 32'(m_err));
`ifdef UART_TX_FIFO_STATS_EN
        check("sent_cnt", 32'(sent_cnt_o), 32'(sent_m));
        check("drop_cnt", 32'(drop_cnt_o), 32'(drop_m));
`endif
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare the DUT.
    task automatic step();
        bit do_pop, accept, room;
        @(posedge clk);
        room   = (q.size() < DEPTH);
        do_pop = (busy_phase == 0) && (q.size() != 0) && !tx_ing;
        accept = wr_en && (room || do_pop) && !flush;
        m_ovf  = wr_en && !accept && !flush;
        m_txen = do_pop;
        m_err  = 0;
        if (do_pop) m_data = q[0];
        if (busy_phase == 0) begin
            if (do_pop) begin
                busy_phase = 1;
                age = 0;
            end
        end else if (busy_phase == 1) begin
            age++;
            if (tx_ing) begin
                busy_phase = 2;
            end else if (age == START_TIMEOUT) begin
                m_err = 1;
                busy_phase = 0;
            end
        end else if (!tx_ing) begin
            busy_phase = 0;
            if (sent_m < 65535) sent_m++;
        end
        if (m_ovf && drop_m < 65535) drop_m++;
`ifdef UART_TX_FIFO_STATS_EN
        if (clr) begin
            sent_m = 0;
            drop_m = 0;
        end
`endif
        if (do_pop) void'(q.pop_front());
        if (accept) q.push_back(wr_data);
        if (flush) q.delete();
        #1;
        check_all();
        if (stub_on) begin
            if (stub_busy > 0) stub_busy--;
            if (m_txen && $urandom_range(0, 7) != 0) stub_busy = $urandom_range(2, 6);
            tx_ing = (stub_busy > 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        int  prob;
        resetn  = 0;
        wr_en   = 0;
        wr_data = 0;
        flush   = 0;
        tx_ing  = 0;
`ifdef UART_TX_FIFO_STATS_EN
        clr     = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_all();
        resetn = 1;
        #2;
        check("reset_empty", 32'(empty_o), 32'd1);
        check("reset_level", 32'(level_o), 32'd0);

        // Single byte into an empty FIFO with the line idle.
        wr_en = 1; wr_data = 8'hA5;
        step();
        wr_en = 0;
        check("a5_level_after_push", 32'(level_o), 32'd1);
        step();
        check("a5_txen", 32'(txen_o), 32'd1);
        check("a5_data", 32'(tx_data_o), 32'hA5);
        check("a5_level_after_pop", 32'(level_o), 32'd0);
        tx_ing = 1;
        repeat (3) step();
        tx_ing = 0;
        repeat (3) step();

        // Fill while the line is busy: 16 bytes fit, the 17th overflows.
        tx_ing = 1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; wr_data = 8'($urandom);
            step();
            if (i == 15) check("fill_full_at_16", 32'(full_o), 32'd1);
            if (i == 16) check("fill_overflow_17", 32'(overflow_o), 32'd1);
        end
        wr_en = 0;
        check("fill_level", 32'(level_o), 32'd16);
        step();

        // Full FIFO: a push in the same cycle as a pop is accepted.
        tx_ing = 0; wr_en = 1; wr_data = 8'($urandom);
        step();
        wr_en = 0;
        check("fullpop_level", 32'(level_o), 32'd16);
        check("fullpop_no_ovf", 32'(overflow_o), 32'd0);
        check("fullpop_txen", 32'(txen_o), 32'd1);

        // The line never starts, so the timeout fires START_TIMEOUT clocks after the strobe.
        n = 0;
        while (!tx_err_o && n < 40) begin
            step();
            n++;
        end
        check("timeout_clocks", 32'(n), 32'(START_TIMEOUT));
        step();
        check("after_timeout_txen", 32'(txen_o), 32'd1);
        check("after_timeout_level", 32'(level_o), 32'd15);

        // A flush during WAIT_DONE empties the queue without aborting the frame.
        tx_ing = 1;
        step();
        flush = 1; step(); flush = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'($urandom);
            step();
        end
        wr_en = 0;
        check("flush_pre_level", 32'(level_o), 32'd5);
        flush = 1; step(); flush = 0;
        check("flush_level", 32'(level_o), 32'd0);
        check("flush_empty", 32'(empty_o), 32'd1);
        seen = 0;
        repeat (2) step();
        tx_ing = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (txen_o) seen = 1;
        end
        check("flush_no_txen", 32'(seen), 32'd0);

`ifdef UART_TX_FIFO_STATS_EN
        clr = 1; step(); clr = 0;
        check("stats_clr_sent", 32'(sent_cnt_o), 32'd0);
        check("stats_clr_drop", 32'(drop_cnt_o), 32'd0);
`endif

        // Randomized traffic against the model, with phases of varying write pressure.
        stub_on = 1;
        for (int ph = 0; ph < 4; ph++) begin
            prob = (ph == 0) ? 20 : (ph == 1) ? 90 : (ph == 2) ? 50 : 95;
            for (int i = 0; i < 150; i++) begin
                wr_en   = ($urandom_range(0, 99) < prob);
                wr_data = 8'($urandom);
                flush   = ($urandom_range(0, 99) == 0);
`ifdef UART_TX_FIFO_STATS_EN
                clr     = ($urandom_range(0, 199) == 0);
`endif
                step();
            end
        end
        wr_en = 0; flush = 0;
`ifdef UART_TX_FIFO_STATS_EN
        clr = 0;
`endif
        repeat (30) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
